// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch next-PC controller.
package fetch_pkg;

    localparam int DEF_PC_W    = 16;
    localparam int DEF_FETCH_W = 4;
    localparam int DEF_MAX_BR  = 4;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_WAIT_JMP = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        TERM_NONE  = 2'd0,
        TERM_JR    = 2'd1,
        TERM_TAKEN = 2'd2,
        TERM_CAP   = 2'd3
    } term_t;

endpackage

// File: rtl/fetch_slot_scan.sv
// Priority scan of one fetch bundle: finds the first slot that ends the bundle
// (register jump, accepted taken branch, or branch blocked by the in-flight cap).
module fetch_slot_scan
    import fetch_pkg::*;
#(
    parameter int FETCH_W = DEF_FETCH_W,
    parameter int MAX_BR  = DEF_MAX_BR,
    parameter int CNT_W   = $clog2(MAX_BR + 1),
    parameter int IDX_W   = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
    input  logic               en,
    input  logic [CNT_W-1:0]   br_cnt,
    input  logic [FETCH_W-1:0] br_valid,
    input  logic [FETCH_W-1:0] br_pred_taken,
    input  logic [FETCH_W-1:0] jr_valid,
    output logic [FETCH_W-1:0] slot_valid,
    output logic [IDX_W-1:0]   term_idx,
    output term_t              term_cause,
    output logic [CNT_W-1:0]   acc_cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BR);

    logic [CNT_W-1:0] running;
    logic             done;

    always_comb begin
        slot_valid = '0;
        term_idx   = '0;
        term_cause = TERM_NONE;
        acc_cnt    = '0;
        running    = br_cnt;
        done       = !en;
        for (int i = 0; i < FETCH_W; i++) begin
            if (!done) begin
                if (jr_valid[i]) begin
                    slot_valid[i] = 1'b1;
                    term_idx      = IDX_W'(i);
                    term_cause    = TERM_JR;
                    done          = 1'b1;
                end else if (br_valid[i]) begin
                    // Running count includes branches accepted earlier in this bundle.
                    if (running == MAX_CNT) begin
                        term_idx   = IDX_W'(i);
                        term_cause = TERM_CAP;
                        done       = 1'b1;
                    end else begin
                        running       = running + CNT_W'(1);
                        acc_cnt       = acc_cnt + CNT_W'(1);
                        slot_valid[i] = 1'b1;
                        if (br_pred_taken[i]) begin
                            term_idx   = IDX_W'(i);
                            term_cause = TERM_TAKEN;
                            done       = 1'b1;
                        end
                    end
                end else begin
                    slot_valid[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage next-PC controller: slot validity, PC redirect and branch count.
// Optional JUMP_BYPASS_EN: a register jump whose base is ready redirects without WAIT_JMP.
//
// state       | meaning
// ST_RUN      | fetching bundles, scanning slots each cycle
// ST_WAIT_JMP | register jump issued, waiting for its base from the register file
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter  int PC_W    = DEF_PC_W,
    parameter  int FETCH_W = DEF_FETCH_W,
    parameter  int MAX_BR  = DEF_MAX_BR,
    localparam int CNT_W   = $clog2(MAX_BR + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall_fetch,
    input  logic                    exter_pc_en,
    input  logic [PC_W-1:0]         exter_pc,
    input  logic                    has_mispredict,
    input  logic [PC_W-1:0]         pc_recovery,
    input  logic [CNT_W-1:0]        br_keep,
    input  logic                    decr_count_brnch,
    input  logic [FETCH_W-1:0]      br_valid,
    input  logic [FETCH_W-1:0]      br_pred_taken,
    input  logic [FETCH_W*PC_W-1:0] br_target,
    input  logic [FETCH_W-1:0]      jr_valid,
    input  logic                    jump_base_rdy_from_rf,
    input  logic [PC_W-1:0]         jump_base_from_rf,
    output logic [PC_W-1:0]         pc,
    output logic [FETCH_W-1:0]      slot_valid,
    output logic [FETCH_W-1:0]      pred_result,
    output logic [CNT_W-1:0]        br_cnt,
    output logic                    stall_for_jump,
    output logic                    stall_for_brnch
);

    localparam int IDX_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

    state_t           state;
    logic             run_en;
    logic [FETCH_W-1:0] scan_valid;
    logic [IDX_W-1:0] term_idx;
    term_t            term_cause;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] cnt_after_decr;
    logic [PC_W-1:0]  pc_jr;
    logic [PC_W-1:0]  pc_cap;
    logic [PC_W-1:0]  pc_seq;
    logic [PC_W-1:0]  pc_tgt;

    assign run_en = rst_n && (state == ST_RUN);

    fetch_slot_scan #(
        .FETCH_W (FETCH_W),
        .MAX_BR  (MAX_BR),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W)
    ) u_scan (
        .en            (run_en),
        .br_cnt        (br_cnt),
        .br_valid      (br_valid),
        .br_pred_taken (br_pred_taken),
        .jr_valid      (jr_valid),
        .slot_valid    (scan_valid),
        .term_idx      (term_idx),
        .term_cause    (term_cause),
        .acc_cnt       (acc_cnt)
    );

    assign slot_valid      = stall_fetch ? '0 : scan_valid;
    assign pred_result     = slot_valid & br_valid & br_pred_taken;
    assign stall_for_jump  = rst_n && (state == ST_WAIT_JMP);
    assign stall_for_brnch = run_en && (term_cause == TERM_CAP) && (term_idx == '0);

    // A resolve with nothing outstanding is dropped so the count cannot underflow.
    assign cnt_after_decr = br_cnt - CNT_W'(decr_count_brnch && (br_cnt != '0));

    assign pc_jr  = pc + PC_W'(term_idx) + PC_W'(1);
    assign pc_cap = pc + PC_W'(term_idx);
    assign pc_seq = pc + PC_W'(FETCH_W);
    assign pc_tgt = br_target[int'(term_idx)*PC_W +: PC_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= '0;
            br_cnt <= '0;
            state  <= ST_RUN;
        end else if (exter_pc_en) begin
            pc     <= exter_pc;
            br_cnt <= '0;
            state  <= ST_RUN;
        end else if (has_mispredict) begin
            pc     <= pc_recovery;
            br_cnt <= br_keep;
            state  <= ST_RUN;
        end else if (stall_fetch) begin
            br_cnt <= cnt_after_decr;
        end else begin
            case (state)
                ST_RUN: begin
                    br_cnt <= cnt_after_decr + acc_cnt;
                    case (term_cause)
                        TERM_JR: begin
`ifdef JUMP_BYPASS_EN
                            if (jump_base_rdy_from_rf) begin
                                pc <= jump_base_from_rf;
                            end else begin
                                pc    <= pc_jr;
                                state <= ST_WAIT_JMP;
                            end
`else
                            pc    <= pc_jr;
                            state <= ST_WAIT_JMP;
`endif
                        end
                        TERM_TAKEN: pc <= pc_tgt;
                        TERM_CAP:   pc <= pc_cap;
                        default:    pc <= pc_seq;
                    endcase
                end
                ST_WAIT_JMP: begin
                    br_cnt <= cnt_after_decr;
                    if (jump_base_rdy_from_rf) begin
                        pc    <= jump_base_from_rf;
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl; expectations follow JUMP_BYPASS_EN when defined.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_fetch;
    logic        exter_pc_en;
    logic [15:0] exter_pc;
    logic        has_mispredict;
    logic [15:0] pc_recovery;
    logic [2:0]  br_keep;
    logic        decr_count_brnch;
    logic [3:0]  br_valid;
    logic [3:0]  br_pred_taken;
    logic [63:0] br_target;
    logic [3:0]  jr_valid;
    logic        jump_base_rdy_from_rf;
    logic [15:0] jump_base_from_rf;
    logic [15:0] pc;
    logic [3:0]  slot_valid;
    logic [3:0]  pred_result;
    logic [2:0]  br_cnt;
    logic        stall_for_jump;
    logic        stall_for_brnch;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .stall_fetch           (stall_fetch),
        .exter_pc_en           (exter_pc_en),
        .exter_pc              (exter_pc),
        .has_mispredict        (has_mispredict),
        .pc_recovery           (pc_recovery),
        .br_keep               (br_keep),
        .decr_count_brnch      (decr_count_brnch),
        .br_valid              (br_valid),
        .br_pred_taken         (br_pred_taken),
        .br_target             (br_target),
        .jr_valid              (jr_valid),
        .jump_base_rdy_from_rf (jump_base_rdy_from_rf),
        .jump_base_from_rf     (jump_base_from_rf),
        .pc                    (pc),
        .slot_valid            (slot_valid),
        .pred_result           (pred_result),
        .br_cnt                (br_cnt),
        .stall_for_jump        (stall_for_jump),
        .stall_for_brnch       (stall_for_brnch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic redirect(input logic [15:0] tgt, input logic [2:0] keep);
        has_mispredict = 1'b1;
        pc_recovery    = tgt;
        br_keep        = keep;
        tick();
        has_mispredict = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall_fetch = 1'b0; exter_pc_en = 1'b0; exter_pc = '0;
        has_mispredict = 1'b0; pc_recovery = '0; br_keep = '0; decr_count_brnch = 1'b0;
        br_valid = '0; br_pred_taken = '0; br_target = '0; jr_valid = '0;
        jump_base_rdy_from_rf = 1'b0; jump_base_from_rf = '0;

        // reset and sequential fetch
        tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_br_cnt", br_cnt, 3'd0);
        chk("rst_slot_valid", slot_valid, 4'b0000);
        chk("rst_stall_jump", stall_for_jump, 1'b0);
        rst_n = 1'b1;
        settle();
        chk("seq_slot_valid", slot_valid, 4'b1111);
        tick();
        chk("seq_pc1", pc, 16'h0004);
        tick();
        chk("seq_pc2", pc, 16'h0008);

        // taken branch in slot 1
        br_valid = 4'b0010; br_pred_taken = 4'b0010;
        br_target = {16'h0000, 16'h0000, 16'h0040, 16'h0000};
        settle();
        chk("tkn_slot_valid", slot_valid, 4'b0011);
        chk("tkn_pred_result", pred_result, 4'b0010);
        tick();
        br_valid = '0; br_pred_taken = '0; br_target = '0;
        chk("tkn_pc", pc, 16'h0040);
        chk("tkn_br_cnt", br_cnt, 3'd1);

        // register jump in slot 2, base arrives later
        exter_pc_en = 1'b1; exter_pc = 16'h0010;
        tick();
        exter_pc_en = 1'b0;
        chk("ext_pc", pc, 16'h0010);
        chk("ext_br_cnt", br_cnt, 3'd0);
        jr_valid = 4'b0100;
        settle();
        chk("jr_slot_valid", slot_valid, 4'b0111);
        tick();
        jr_valid = '0;
        chk("jr_pc", pc, 16'h0013);
        for (int i = 0; i < 3; i++) begin
            chk("jr_wait_stall", stall_for_jump, 1'b1);
            chk("jr_wait_slots", slot_valid, 4'b0000);
            tick();
            chk("jr_wait_pc", pc, 16'h0013);
        end
        jump_base_rdy_from_rf = 1'b1; jump_base_from_rf = 16'h1234;
        tick();
        jump_base_rdy_from_rf = 1'b0;
        chk("jr_base_pc", pc, 16'h1234);
        chk("jr_base_run", stall_for_jump, 1'b0);

        // register jump with base ready in the same cycle
        exter_pc_en = 1'b1; exter_pc = 16'h0010;
        tick();
        exter_pc_en = 1'b0;
        jr_valid = 4'b0100; jump_base_rdy_from_rf = 1'b1; jump_base_from_rf = 16'h1234;
        tick();
        jr_valid = '0;
`ifdef JUMP_BYPASS_EN
        chk("byp_pc", pc, 16'h1234);
        chk("byp_no_wait", stall_for_jump, 1'b0);
`else
        chk("nobyp_pc", pc, 16'h0013);
        chk("nobyp_wait", stall_for_jump, 1'b1);
        tick();
        chk("nobyp_base_pc", pc, 16'h1234);
        chk("nobyp_run", stall_for_jump, 1'b0);
`endif
        jump_base_rdy_from_rf = 1'b0;

        // branch cap
        redirect(16'h0020, 3'd3);
        chk("cap_setup_pc", pc, 16'h0020);
        chk("cap_setup_cnt", br_cnt, 3'd3);
        br_valid = 4'b0101;
        settle();
        chk("cap_slot_valid", slot_valid, 4'b0011);
        chk("cap_no_stall", stall_for_brnch, 1'b0);
        tick();
        chk("cap_pc", pc, 16'h0022);
        chk("cap_cnt", br_cnt, 3'd4);
        br_valid = 4'b0001;
        settle();
        chk("cap_stall_brnch", stall_for_brnch, 1'b1);
        chk("cap_stall_slots", slot_valid, 4'b0000);
        tick();
        chk("cap_hold_pc", pc, 16'h0022);
        decr_count_brnch = 1'b1;
        settle();
        chk("cap_no_fwd", stall_for_brnch, 1'b1);
        tick();
        decr_count_brnch = 1'b0;
        chk("cap_decr_cnt", br_cnt, 3'd3);
        chk("cap_decr_pc", pc, 16'h0022);
        settle();
        chk("cap_refetch_slots", slot_valid, 4'b1111);
        chk("cap_refetch_nostall", stall_for_brnch, 1'b0);
        tick();
        br_valid = '0;
        chk("cap_refetch_pc", pc, 16'h0026);
        chk("cap_refetch_cnt", br_cnt, 3'd4);

        // mispredict out of a stalled WAIT_JMP
        redirect(16'h0010, 3'd3);
        jr_valid = 4'b0100;
        tick();
        jr_valid = '0;
        chk("mp_wait", stall_for_jump, 1'b1);
        stall_fetch = 1'b1;
        tick();
        chk("mp_stall_hold", pc, 16'h0013);
        redirect(16'h0100, 3'd1);
        chk("mp_pc", pc, 16'h0100);
        chk("mp_cnt", br_cnt, 3'd1);
        chk("mp_run", stall_for_jump, 1'b0);
        chk("mp_stall_slots", slot_valid, 4'b0000);
        stall_fetch = 1'b0;

        // external load beats mispredict
        redirect(16'h0010, 3'd3);
        jr_valid = 4'b0100;
        tick();
        jr_valid = '0;
        chk("ext_mp_wait", stall_for_jump, 1'b1);
        exter_pc_en = 1'b1; exter_pc = 16'h0200;
        has_mispredict = 1'b1; pc_recovery = 16'h0100; br_keep = 3'd1;
        tick();
        exter_pc_en = 1'b0; has_mispredict = 1'b0;
        chk("ext_mp_pc", pc, 16'h0200);
        chk("ext_mp_cnt", br_cnt, 3'd0);
        chk("ext_mp_run", stall_for_jump, 1'b0);

        // PC wrap and decrement at zero
        exter_pc_en = 1'b1; exter_pc = 16'hFFFC;
        tick();
        exter_pc_en = 1'b0;
        settle();
        chk("wrap_slots", slot_valid, 4'b1111);
        tick();
        chk("wrap_pc", pc, 16'h0000);
        decr_count_brnch = 1'b1;
        tick();
        decr_count_brnch = 1'b0;
        chk("decr_zero_cnt", br_cnt, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
